mem_arbiter: RTL

//  Two-requester burst arbiter in front of the single-port synchronous 64K x 8 memory.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port burst arbiter in front of a single-port synchronous 64K x 8 memory.
// Define MEM_ARB_RR_EN for round-robin priority; otherwise port 0 always wins.
module mem_arbiter #(
    parameter int BURST_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Req0,
    input  logic               Req1,
    input  logic               We0,
    input  logic               We1,
    input  logic [15:0]        Addr0,
    input  logic [15:0]        Addr1,
    input  logic [BURST_W-1:0] Len0,
    input  logic [BURST_W-1:0] Len1,
    input  logic [7:0]         Wdata0,
    input  logic [7:0]         Wdata1,
    output logic               Ack0,
    output logic               Ack1,
    output logic               Rvalid0,
    output logic               Rvalid1,
    output logic [7:0]         Rdata0,
    output logic [7:0]         Rdata1,
    output logic               Busy,
    output logic               MemWE,
    output logic [15:0]        MemAddress,
    output logic [7:0]         MemDataIn,
    input  logic [7:0]         MemDataOut
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_next;
    logic               owner, owner_next;
    logic               we_r, we_next;
    logic [15:0]        addr_r, addr_next;
    logic [BURST_W-1:0] cnt_r, cnt_next;
    logic               winner;
    logic               rd_beat;
    logic [7:0]         rdata0_q, rdata1_q;

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    // On contention the port that did not win the previous grant goes first.
    always_comb begin
        winner = ~Req0;
        if (Req0 && Req1) begin
            winner = ~last_owner;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_owner <= 1'b1;
        end else if (state == IDLE && (Req0 || Req1)) begin
            last_owner <= winner;
        end
    end
`else
    assign winner = ~Req0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            owner  <= 1'b0;
            we_r   <= 1'b0;
            addr_r <= 16'h0000;
            cnt_r  <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            we_r   <= we_next;
            addr_r <= addr_next;
            cnt_r  <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        we_next    = we_r;
        addr_next  = addr_r;
        cnt_next   = cnt_r;
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_next = BURST;
                    owner_next = winner;
                    we_next    = winner ? We1 : We0;
                    addr_next  = winner ? Addr1 : Addr0;
                    cnt_next   = winner ? Len1 : Len0;
                end
            end
            BURST: begin
                addr_next = addr_r + 16'd1;
                cnt_next  = cnt_r - BURST_W'(1);
                if (cnt_r == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ack and write enable are gated by reset so an aborted beat never writes.
    always_comb begin
        Busy       = (state == BURST);
        Ack0       = Busy && !RST && !owner;
        Ack1       = Busy && !RST && owner;
        MemWE      = Busy && !RST && we_r;
        MemAddress = addr_r;
        MemDataIn  = 8'h00;
        if (Busy && we_r) begin
            MemDataIn = owner ? Wdata1 : Wdata0;
        end
    end

    assign rd_beat = (state == BURST) && !we_r;

    always_ff @(posedge CLK) begin
        if (RST) begin
            Rvalid0  <= 1'b0;
            Rvalid1  <= 1'b0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            Rvalid0 <= rd_beat && !owner;
            Rvalid1 <= rd_beat && owner;
            if (Rvalid0) begin
                rdata0_q <= MemDataOut;
            end
            if (Rvalid1) begin
                rdata1_q <= MemDataOut;
            end
        end
    end

    // The memory output register already holds the beat's data in the Rvalid
    // cycle, so it is forwarded then and held in rdata*_q afterwards.
    assign Rdata0 = Rvalid0 ? MemDataOut : rdata0_q;
    assign Rdata1 = Rvalid1 ? MemDataOut : rdata1_q;

endmodule
